// File: rtl/freq_gate_sequencer.sv
// rtl/freq_gate_sequencer.sv - gated edge counter with decile digit output for the freq-counter tile
// Sequences IDLE -> GATE -> LATCH -> HOLD, counting both sig polarities inside each gate window.
module freq_gate_sequencer #(
  parameter int GATE_CYCLES = 200,
  parameter int HOLD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] count_o,
  output logic [3:0]       digit_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             gate_go;
  logic             sig_d1;
  logic             sig_d2;
  logic             edge_w;
  logic [GW-1:0]    gate_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [CNT_W-1:0] edge_cnt;

  // Decile index: number of thresholds T_k = ceil(GATE_CYCLES*k/10) that c strictly exceeds.
  function automatic logic [3:0] digit_of(input logic [CNT_W-1:0] c);
    logic [3:0] d;
    d = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (int'(c) > (GATE_CYCLES * k + 9) / 10) d = d + 4'd1;
    end
    return d;
  endfunction

  assign edge_w = sig_d1 ^ sig_d2;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    gate_go = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = GATE;
          gate_go = 1'b1;
        end
      end
      GATE: begin
        if (gate_cnt == '0) state_n = LATCH;
      end
      LATCH: begin
        state_n = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (cont) begin
            state_n = GATE;
            gate_go = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_d1     <= 1'b0;
      sig_d2     <= 1'b0;
      gate_cnt   <= '0;
      hold_cnt   <= '0;
      edge_cnt   <= '0;
      count_o    <= '0;
      digit_o    <= 4'd0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      sig_d1  <= sig;
      sig_d2  <= sig_d1;
      valid_o <= 1'b0;

      if (gate_go) begin
        gate_cnt <= GATE_LOAD;
        edge_cnt <= '0;
      end else if (state == GATE) begin
        if (gate_cnt != '0) gate_cnt <= gate_cnt - GATE_ONE;
        // Counter sticks at full scale; an edge arriving there marks the window as clipped.
        if (edge_w) begin
          if (edge_cnt == CNT_MAX) overflow_o <= 1'b1;
          else                     edge_cnt   <= edge_cnt + CNT_ONE;
        end
      end

      if (state == LATCH) begin
        count_o  <= edge_cnt;
        digit_o  <= digit_of(edge_cnt);
        valid_o  <= 1'b1;
        hold_cnt <= HOLD_LOAD;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// tb/tb_freq_gate_sequencer.sv - randomized self-checking bench for freq_gate_sequencer
// Expected counts come from the recorded sig samples and the gate window placement.
module tb_freq_gate_sequencer;
  localparam int G = 20;
  localparam int H = 4;
  localparam int DEPTH = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sig = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       busy, valid, ovf;
  logic [7:0] count;
  logic [3:0] digit;
  logic       busy4, valid4, ovf4;
  logic [3:0] count4;
  logic [3:0] digit4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic samp [0:DEPTH-1];
  logic ov4_exp = 1'b0;

  freq_gate_sequencer #(.GATE_CYCLES(G), .HOLD_CYCLES(H), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .sig(sig), .start(start), .cont(cont),
    .busy(busy), .count_o(count), .digit_o(digit), .valid_o(valid), .overflow_o(ovf)
  );

  freq_gate_sequencer #(.GATE_CYCLES(G), .HOLD_CYCLES(H), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .sig(sig), .start(start), .cont(cont),
    .busy(busy4), .count_o(count4), .digit_o(digit4), .valid_o(valid4), .overflow_o(ovf4)
  );

  always #5 clk = ~clk;

  // samp[e] is the sig value the synchronizer holds after edge e (reset forces 0).
  always @(posedge clk) begin
    samp[cyc % DEPTH] <= reset ? 1'b0 : sig;
    cyc <= cyc + 1;
  end

  function automatic logic pat(input int mode, input int e);
    case (mode)
      1:       return logic'(e % 2);
      2:       return logic'((e / 2) % 2);
      3:       return logic'((e / 4) % 2);
      4:       return logic'($urandom % 2);
      default: return 1'b0;
    endcase
  endfunction

  // Toggles sampled at edges s..s+G-1 fall inside a window whose start is sampled at edge s.
  function automatic int raw_edges(input int s);
    int r = 0;
    for (int n = s; n < s + G; n++)
      if (samp[n % DEPTH] !== samp[(n - 1) % DEPTH]) r++;
    return r;
  endfunction

  function automatic int sat(input int r, input int w);
    int mx = (1 << w) - 1;
    return (r > mx) ? mx : r;
  endfunction

  function automatic int digit_ref(input int c);
    int t [1:9];
    for (int k = 1; k <= 9; k++) t[k] = int'($ceil(real'(G * k) / 10.0));
    if (c <= t[1]) return 0;
    if (c > t[9]) return 9;
    for (int k = 1; k <= 8; k++)
      if (c > t[k] && c <= t[k + 1]) return k;
    return -1;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%0b still high after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic do_window(input int mode, output int s, output int vcyc);
    int i = 0;
    repeat (2) begin
      @(negedge clk);
      sig = pat(mode, cyc);
    end
    @(negedge clk);
    sig = pat(mode, cyc);
    start = 1'b1;
    s = cyc;
    vcyc = -1;
    while (vcyc < 0 && i < 40) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) vcyc = cyc;
      else sig = pat(mode, cyc);
      i++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, valid, ovf, count, digit} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_main: busy/valid/ovf/count/digit=%b required all 0", {busy, valid, ovf, count, digit});
    end
    n_cmp++;
    if ({busy4, valid4, ovf4, count4, digit4} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_w4: busy/valid/ovf/count/digit=%b required all 0", {busy4, valid4, ovf4, count4, digit4});
    end
  endtask

  task automatic test_zero();
    int s, v, k;
    do_window(0, s, v);
    n_cmp++;
    if (v - s != G + 2) begin
      n_err++;
      $display("FAIL zero_latency: valid at %0d cycles, required %0d", v - s, G + 2);
    end
    n_cmp++;
    if (count !== 8'd0 || digit !== 4'd0) begin
      n_err++;
      $display("FAIL zero_result: count=%0d digit=%0d, required 0/0", count, digit);
    end
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_width: valid=%0b one cycle after pulse, required 0", valid);
    end
    k = 1;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != H) begin
      n_err++;
      $display("FAIL busy_fall: busy fell %0d cycles after valid, required %0d", k, H);
    end
  endtask

  task automatic test_patterns();
    int modes [3] = '{2, 1, 3};
    int ecnt [3] = '{10, 20, 5};
    int edig [3] = '{4, 9, 2};
    int s, v, r;
    for (int i = 0; i < 3; i++) begin
      do_window(modes[i], s, v);
      r = raw_edges(s);
      if (r > 15) ov4_exp = 1'b1;
      n_cmp++;
      if (int'(count) != ecnt[i] || int'(digit) != edig[i] || int'(count) != r) begin
        n_err++;
        $display("FAIL pattern_%0d: count=%0d digit=%0d, required %0d/%0d (model %0d)",
                 modes[i], count, digit, ecnt[i], edig[i], r);
      end
      n_cmp++;
      if (int'(count4) != sat(r, 4) || int'(digit4) != digit_ref(sat(r, 4)) || ovf4 !== ov4_exp) begin
        n_err++;
        $display("FAIL pattern_w4_%0d: count=%0d digit=%0d ovf=%0b, required %0d/%0d/%0b",
                 modes[i], count4, digit4, ovf4, sat(r, 4), digit_ref(sat(r, 4)), ov4_exp);
      end
      wait_idle();
    end
  endtask

  task automatic test_random();
    int s, v, r;
    for (int i = 0; i < 6; i++) begin
      do_window(4, s, v);
      r = raw_edges(s);
      if (r > 15) ov4_exp = 1'b1;
      n_cmp++;
      if (v - s != G + 2 || int'(count) != r || int'(digit) != digit_ref(r) || ovf !== 1'b0) begin
        n_err++;
        $display("FAIL random_%0d: lat=%0d count=%0d digit=%0d ovf=%0b, required %0d/%0d/%0d/0",
                 i, v - s, count, digit, ovf, G + 2, r, digit_ref(r));
      end
      n_cmp++;
      if (int'(count4) != sat(r, 4) || ovf4 !== ov4_exp) begin
        n_err++;
        $display("FAIL random_w4_%0d: count=%0d ovf=%0b, required %0d/%0b", i, count4, ovf4, sat(r, 4), ov4_exp);
      end
      wait_idle();
    end
  endtask

  task automatic test_continuous();
    int vc [$];
    int cn [$];
    int i = 0;
    cont = 1'b1;
    @(negedge clk);
    sig = pat(2, cyc);
    start = 1'b1;
    while (vc.size() < 3 && i < 120) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) begin
        vc.push_back(cyc);
        cn.push_back(int'(count));
      end
      sig = pat(2, cyc);
      i++;
    end
    cont = 1'b0;
    n_cmp++;
    if (vc.size() != 3) begin
      n_err++;
      $display("FAIL cont_pulses: saw %0d valid pulses, required 3", vc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (cn[k] != 10 || cn[k] != raw_edges(vc[k] - G - 2)) begin
          n_err++;
          $display("FAIL cont_count_%0d: count=%0d, required 10 (model %0d)", k, cn[k], raw_edges(vc[k] - G - 2));
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (vc[k] - vc[k - 1] != G + 1 + H) begin
          n_err++;
          $display("FAIL cont_period_%0d: %0d cycles, required %0d", k, vc[k] - vc[k - 1], G + 1 + H);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_start_held();
    int vc [$];
    int cn [$];
    int i = 0;
    start = 1'b1;
    while (vc.size() < 2 && i < 120) begin
      @(negedge clk);
      if (valid) begin
        vc.push_back(cyc);
        cn.push_back(int'(count));
      end
      sig = pat(3, cyc);
      i++;
    end
    start = 1'b0;
    n_cmp++;
    if (vc.size() != 2) begin
      n_err++;
      $display("FAIL held_pulses: saw %0d valid pulses, required 2", vc.size());
    end else begin
      n_cmp++;
      if (vc[1] - vc[0] != G + 2 + H) begin
        n_err++;
        $display("FAIL held_period: %0d cycles, required %0d", vc[1] - vc[0], G + 2 + H);
      end
      n_cmp++;
      if (cn[1] != 5 || cn[1] != raw_edges(vc[1] - G - 2)) begin
        n_err++;
        $display("FAIL held_count: count=%0d, required 5", cn[1]);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int s, v, r;
    int seen = 0;
    @(negedge clk);
    sig = pat(1, cyc);
    start = 1'b1;
    s = cyc;
    while (cyc < s + 10) begin
      @(negedge clk);
      start = 1'b0;
      sig = pat(1, cyc);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ov4_exp = 1'b0;
    n_cmp++;
    if ({busy, valid, count, digit, ovf4} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy/valid/count/digit/ovf4=%b, required all 0", {busy, valid, count, digit, ovf4});
    end
    repeat (30) begin
      @(negedge clk);
      sig = pat(1, cyc);
      if (valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_valid: %0d pulses busy=%0b, required 0/0", seen, busy);
    end
    do_window(1, s, v);
    r = raw_edges(s);
    if (r > 15) ov4_exp = 1'b1;
    n_cmp++;
    if (v - s != G + 2 || count !== 8'd20 || int'(count) != r) begin
      n_err++;
      $display("FAIL reset_next_window: lat=%0d count=%0d, required %0d/20", v - s, count, G + 2);
    end
    n_cmp++;
    if (count4 !== 4'd15 || ovf4 !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_set: count4=%0d ovf4=%0b, required 15/1", count4, ovf4);
    end
    wait_idle();
  endtask

  task automatic test_overflow_sticky();
    int s, v;
    do_window(0, s, v);
    n_cmp++;
    if (count4 !== 4'd0 || ovf4 !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky: count4=%0d ovf4=%0b, required 0/1", count4, ovf4);
    end
    wait_idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ov4_exp = 1'b0;
    n_cmp++;
    if (ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear: ovf4=%0b after reset, required 0", ovf4);
    end
  endtask

  task automatic test_sig_after_reset();
    int s, r;
    int v = -1;
    int i = 0;
    @(negedge clk);
    reset = 1'b1;
    sig = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    s = cyc;
    while (v < 0 && i < 40) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) v = cyc;
      i++;
    end
    r = raw_edges(s);
    n_cmp++;
    if (v - s != G + 2 || count !== 8'd1 || int'(count) != r) begin
      n_err++;
      $display("FAIL sig_high_reset: lat=%0d count=%0d, required %0d/1", v - s, count, G + 2);
    end
    wait_idle();
    sig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_patterns();
    test_random();
    test_continuous();
    test_start_held();
    test_reset_mid();
    test_overflow_sticky();
    test_sig_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
